// File: rtl/tremolo_effect.sv
// Tremolo pedal: scales each 16-bit signed frame by a triangle-LFO gain in 128..255,
// served through a START/DONE four-phase handshake (IDLE -> MULT -> HOLD).
module tremolo_effect #(
    parameter int unsigned STEP_SLOW = 1,
    parameter int unsigned STEP_FAST = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        START,
    input  logic [15:0] in,
    input  logic        speed,
    output logic        DONE,
    output logic [15:0] out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [8:0] STEP_SLOW_W = 9'(STEP_SLOW);
    localparam logic [8:0] STEP_FAST_W = 9'(STEP_FAST);

    state_t             state_q;
    logic signed [15:0] sample_q;
    logic [7:0]         gain_q;
    logic [7:0]         lfo_q;
    logic [7:0]         lfo_d;
    logic               dir_down_q;
    logic               dir_down_d;
    logic               done_q;
    logic [15:0]        out_q;

    logic [8:0]         step_s;
    logic [8:0]         sum_s;
    logic signed [24:0] prod_s;
    logic               unused_prod_s;

    // Gain is zero-extended so the multiply stays signed with a positive multiplier.
    assign prod_s        = sample_q * $signed({1'b0, gain_q});
    assign unused_prod_s = ^{prod_s[24], prod_s[7:0]};

    // Next triangle-LFO position, evaluated in 9 bits so the turn points clamp instead of wrapping.
    always_comb begin
        step_s     = speed ? STEP_FAST_W : STEP_SLOW_W;
        sum_s      = {1'b0, lfo_q} + step_s;
        lfo_d      = lfo_q;
        dir_down_d = dir_down_q;
        if (!dir_down_q) begin
            if (sum_s >= 9'd255) begin
                lfo_d      = 8'd255;
                dir_down_d = 1'b1;
            end else begin
                lfo_d      = sum_s[7:0];
                dir_down_d = 1'b0;
            end
        end else begin
            if ({1'b0, lfo_q} <= step_s) begin
                lfo_d      = 8'd0;
                dir_down_d = 1'b0;
            end else begin
                lfo_d      = lfo_q - step_s[7:0];
                dir_down_d = 1'b1;
            end
        end
    end

    // Handshake FSM with registered DONE/out; the LFO only moves when a frame is released.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            sample_q   <= 16'sd0;
            gain_q     <= 8'd0;
            lfo_q      <= 8'd0;
            dir_down_q <= 1'b0;
            done_q     <= 1'b0;
            out_q      <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        sample_q <= in;
                        gain_q   <= {1'b1, lfo_q[7:1]};
                        state_q  <= MULT;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                MULT: begin
                    out_q   <= prod_s[23:8];
                    done_q  <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (!START) begin
                        done_q     <= 1'b0;
                        lfo_q      <= lfo_d;
                        dir_down_q <= dir_down_d;
                        state_q    <= IDLE;
                    end else begin
                        state_q    <= HOLD;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign DONE = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_tremolo_effect.sv
// Self-checking bench for tremolo_effect: directed vector table, handshake corner cases,
// and randomized frames checked against an arithmetic LFO/gain model.
module tb_tremolo_effect;

    logic        clk_s;
    logic        reset_s;
    logic        start_s;
    logic [15:0] in_s;
    logic        speed_s;
    logic        done_s;
    logic [15:0] out_s;

    int n_checks;
    int n_fail;

    // Reference model state: LFO position and direction.
    int m_lfo;
    bit m_up;

    typedef struct {
        logic [15:0] din;
        logic        sp;
        int          hold_extra;
        bit          early;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];

    tremolo_effect #(.STEP_SLOW(1), .STEP_FAST(4)) dut (
        .Clk   (clk_s),
        .Reset (reset_s),
        .START (start_s),
        .in    (in_s),
        .speed (speed_s),
        .DONE  (done_s),
        .out   (out_s)
    );

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_out(input logic [15:0] x);
        int g;
        int p;
        g = 128 + m_lfo / 2;
        p = int'($signed(x)) * g;
        p = p >>> 8;
        return p[15:0];
    endfunction

    task automatic model_advance(input logic sp);
        int s;
        s = sp ? 4 : 1;
        if (m_up) begin
            if (m_lfo + s >= 255) begin
                m_lfo = 255;
                m_up  = 1'b0;
            end else begin
                m_lfo = m_lfo + s;
            end
        end else begin
            if (m_lfo <= s) begin
                m_lfo = 0;
                m_up  = 1'b1;
            end else begin
                m_lfo = m_lfo - s;
            end
        end
    endtask

    // One complete handshake starting from IDLE; returns the frame the DUT delivered.
    task automatic frame(input logic [15:0] din, input logic sp, input int hold_extra,
                         input bit early, output logic [15:0] got);
        logic [15:0] exp;
        exp = model_out(din);
        @(negedge clk_s);
        in_s    = din;
        speed_s = sp;
        start_s = 1'b1;
        @(posedge clk_s); #1;
        check("done_low_at_accept", {15'd0, done_s}, 16'd0);
        in_s = 16'($urandom);
        if (early) start_s = 1'b0;
        @(posedge clk_s); #1;
        check("done_latency", {15'd0, done_s}, 16'd1);
        got = out_s;
        check("out_vs_model", out_s, exp);
        if (early) begin
            @(posedge clk_s); #1;
            check("early_drop_done_pulse", {15'd0, done_s}, 16'd0);
        end else begin
            for (int i = 0; i < hold_extra; i++) begin
                @(posedge clk_s); #1;
                check("hold_done", {15'd0, done_s}, 16'd1);
                check("hold_out_stable", out_s, got);
            end
            @(negedge clk_s);
            start_s = 1'b0;
            @(posedge clk_s); #1;
            check("done_release", {15'd0, done_s}, 16'd0);
        end
        model_advance(sp);
    endtask

    task automatic do_reset();
        @(negedge clk_s);
        #2 reset_s = 1'b1;
        start_s = 1'b0;
        #1;
        check("reset_done", {15'd0, done_s}, 16'd0);
        check("reset_out", out_s, 16'h0000);
        @(negedge clk_s);
        reset_s = 1'b0;
        m_lfo = 0;
        m_up  = 1'b1;
    endtask

    initial begin
        logic [15:0] got;
        n_checks = 0;
        n_fail   = 0;
        m_lfo    = 0;
        m_up     = 1'b1;

        vecs[0] = '{16'h4000, 1'b0, 0,  1'b0, 16'h2000};
        vecs[1] = '{16'h8000, 1'b0, 10, 1'b0, 16'hC000};
        vecs[2] = '{16'h0100, 1'b0, 0,  1'b1, 16'h0081};
        vecs[3] = '{16'hFFFF, 1'b0, 0,  1'b0, 16'hFFFF};
        vecs[4] = '{16'h7FFF, 1'b0, 3,  1'b0, 16'h40FF};
        vecs[5] = '{16'hC000, 1'b1, 0,  1'b0, 16'hDF80};
        vecs[6] = '{16'h4000, 1'b0, 0,  1'b0, 16'h2100};

        reset_s = 1'b1;
        start_s = 1'b0;
        in_s    = 16'h0000;
        speed_s = 1'b0;
        #2;
        check("por_done", {15'd0, done_s}, 16'd0);
        check("por_out", out_s, 16'h0000);
        @(negedge clk_s);
        @(negedge clk_s);
        reset_s = 1'b0;

        for (int v = 0; v < 7; v++) begin
            frame(vecs[v].din, vecs[v].sp, vecs[v].hold_extra, vecs[v].early, got);
            check($sformatf("vec%0d_out", v), got, vecs[v].exp);
        end

        // Reset while holding DONE high mid-cycle.
        @(negedge clk_s);
        in_s    = 16'h1234;
        start_s = 1'b1;
        @(posedge clk_s);
        @(posedge clk_s); #1;
        check("pre_reset_done", {15'd0, done_s}, 16'd1);
        #2 reset_s = 1'b1;
        #1;
        check("midhold_reset_done", {15'd0, done_s}, 16'd0);
        check("midhold_reset_out", out_s, 16'h0000);
        start_s = 1'b0;
        @(negedge clk_s);
        reset_s = 1'b0;
        m_lfo = 0;
        m_up  = 1'b1;
        frame(16'h0100, 1'b0, 0, 1'b0, got);
        check("post_reset_g128", got, 16'h0080);

        // Slow sweep up to the top turn.
        do_reset();
        for (int f = 0; f < 254; f++) begin
            frame(16'($urandom), 1'b0, int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0), got);
        end
        frame(16'h7FFF, 1'b0, 0, 1'b0, got);
        check("slow_peak_7fff", got, 16'h7F7F);
        for (int f = 0; f < 3; f++) begin
            frame(16'($urandom), 1'b0, 0, 1'b0, got);
        end

        // Fast sweep to the turning frame, then mixed speeds.
        do_reset();
        for (int f = 0; f < 64; f++) begin
            frame(16'($urandom), 1'b1, 0, ($urandom_range(0, 7) == 0), got);
        end
        frame(16'hFFFF, 1'b1, 0, 1'b0, got);
        check("fast_turn_ffff", got, 16'hFFFF);
        for (int f = 0; f < 150; f++) begin
            frame(16'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                  ($urandom_range(0, 5) == 0), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
